// File: rtl/pid_sample_scheduler_pkg.sv
// rtl/pid_sample_scheduler_pkg.sv - shared types, constants and duty saturation helper
package pid_sample_scheduler_pkg;

  localparam int NUM_CH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_APPLY
  } state_e;

  typedef struct packed {
    logic        dir;
    logic [15:0] duty;
  } sat_t;

  // Magnitude is computed in 17 bits so that -32768 becomes +32768 and saturates.
  function automatic sat_t sat_abs(input logic [15:0] result, input logic [15:0] duty_max);
    logic [16:0] mag;
    sat_t        s;
    mag    = result[15] ? (17'd0 - {result[15], result}) : {1'b0, result};
    s.dir  = result[15];
    s.duty = (mag > {1'b0, duty_max}) ? duty_max : mag[15:0];
    return s;
  endfunction

endpackage

// File: rtl/pid_sample_scheduler_sample_tick_gen.sv
// rtl/pid_sample_scheduler_sample_tick_gen.sv - free-running divider producing the control sample tick
module sample_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pid_sample_scheduler.sv
// rtl/pid_sample_scheduler.sv - sequences one shared PID unit over both motor channels per sample
module pid_sample_scheduler
  import pid_sample_scheduler_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 100000,
  parameter int unsigned PWM_W       = 10,
  parameter int unsigned DUTY_MAX    = 1000,
  parameter int unsigned PID_TIMEOUT = 255
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESET,
  input  logic                     enable,
  input  logic signed [15:0]       enc_count_0,
  input  logic signed [15:0]       enc_count_1,
  input  logic                     sp_wr,
  input  logic                     sp_ch,
  input  logic signed [15:0]       sp_data,
  output logic                     pid_start,
  output logic                     pid_ch,
  output logic signed [15:0]       pid_setpoint,
  output logic signed [15:0]       pid_meas,
  input  logic                     pid_done,
  input  logic signed [15:0]       pid_result,
  output logic [PWM_W-1:0]         duty_0,
  output logic [PWM_W-1:0]         duty_1,
  output logic                     dir_0,
  output logic                     dir_1,
  output logic                     sample_tick,
  output logic                     update_done,
  output logic                     overrun,
  output logic [NUM_CH-1:0]        timeout_flt,
  input  logic                     flt_clr
);

  localparam int unsigned TW = $clog2(PID_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              ch_q, ch_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              got_q, got_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       enc      [NUM_CH];
  logic [15:0]       prev_q   [NUM_CH];
  logic [15:0]       prev_d   [NUM_CH];
  logic [15:0]       meas_q   [NUM_CH];
  logic [15:0]       meas_d   [NUM_CH];
  logic [15:0]       shadow_q [NUM_CH];
  logic [15:0]       shadow_d [NUM_CH];
  logic [15:0]       active_q [NUM_CH];
  logic [15:0]       active_d [NUM_CH];
  logic [15:0]       held_q   [NUM_CH];
  logic [15:0]       held_d   [NUM_CH];
  logic [PWM_W-1:0]  duty_q   [NUM_CH];
  logic [PWM_W-1:0]  duty_d   [NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH-1:0] tmo_q, tmo_d;
  sat_t              sat_c    [NUM_CH];

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk_i  (CLK100MHZ),
    .rst_i  (CPU_RESET),
    .tick_o (sample_tick)
  );

  assign enc[0] = enc_count_0;
  assign enc[1] = enc_count_1;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sat_c[i] = sat_abs(held_q[i], 16'(DUTY_MAX));
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wait_d    = wait_q;
    got_d     = got_q;
    res_d     = res_q;
    prev_d    = prev_q;
    meas_d    = meas_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    held_d    = held_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    overrun_d = flt_clr ? 1'b0 : overrun_q;
    tmo_d     = flt_clr ? '0 : tmo_q;

    if (sample_tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
    // LATCH copies shadow_q, so a write landing in that cycle waits for the next sample.
    if (sp_wr) begin
      shadow_d[sp_ch] = sp_data;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      got_d   = 1'b0;
      dir_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        held_d[i] = '0;
        duty_d[i] = '0;
        if (sample_tick) begin
          prev_d[i] = enc[i];
        end
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sample_tick) begin
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          for (int i = 0; i < NUM_CH; i++) begin
            meas_d[i]   = enc[i] - prev_q[i];
            prev_d[i]   = enc[i];
            active_d[i] = shadow_q[i];
          end
          ch_d    = 1'b0;
          state_d = ST_START;
        end
        ST_START: begin
          wait_d  = '0;
          got_d   = 1'b0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (pid_done) begin
            got_d   = 1'b1;
            res_d   = pid_result;
            state_d = ST_STORE;
          end else if (wait_q == TW'(PID_TIMEOUT - 1)) begin
            tmo_d[ch_q] = 1'b1;
            state_d     = ST_STORE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_STORE: begin
          if (got_q) begin
            held_d[ch_q] = res_q;
          end
          if (ch_q == 1'b0) begin
            ch_d    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_APPLY;
          end
        end
        ST_APPLY: begin
          for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = PWM_W'(sat_c[i].duty);
            dir_d[i]  = sat_c[i].dir;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state_q   <= ST_IDLE;
      ch_q      <= 1'b0;
      wait_q    <= '0;
      got_q     <= 1'b0;
      res_q     <= '0;
      prev_q    <= '{default: '0};
      meas_q    <= '{default: '0};
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      held_q    <= '{default: '0};
      duty_q    <= '{default: '0};
      dir_q     <= '0;
      overrun_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wait_q    <= wait_d;
      got_q     <= got_d;
      res_q     <= res_d;
      prev_q    <= prev_d;
      meas_q    <= meas_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      held_q    <= held_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
    end
  end

  assign pid_start    = (state_q == ST_START) && enable;
  assign pid_ch       = ch_q;
  assign pid_setpoint = active_q[ch_q];
  assign pid_meas     = meas_q[ch_q];
  assign update_done  = (state_q == ST_APPLY);
  assign duty_0       = duty_q[0];
  assign duty_1       = duty_q[1];
  assign dir_0        = dir_q[0];
  assign dir_1        = dir_q[1];
  assign overrun      = overrun_q;
  assign timeout_flt  = tmo_q;

endmodule

// File: tb/tb_pid_sample_scheduler.sv
// tb/tb_pid_sample_scheduler.sv - bench with event-time model, stub PID unit and directed samples
module tb_pid_sample_scheduler;

  localparam int DIV = 16;
  localparam int TO  = 255;

  logic               clk = 1'b0;
  logic               CPU_RESET;
  logic               enable;
  logic signed [15:0] enc_count_0, enc_count_1;
  logic               sp_wr, sp_ch;
  logic signed [15:0] sp_data;
  logic               pid_start, pid_ch;
  logic signed [15:0] pid_setpoint, pid_meas;
  logic               pid_done;
  logic signed [15:0] pid_result;
  logic [9:0]         duty_0, duty_1;
  logic               dir_0, dir_1, sample_tick, update_done, overrun, flt_clr;
  logic [1:0]         timeout_flt;

  pid_sample_scheduler #(.SAMPLE_DIV(DIV), .PWM_W(10), .DUTY_MAX(1000), .PID_TIMEOUT(TO)) dut (
    .CLK100MHZ(clk), .CPU_RESET(CPU_RESET), .enable(enable),
    .enc_count_0(enc_count_0), .enc_count_1(enc_count_1),
    .sp_wr(sp_wr), .sp_ch(sp_ch), .sp_data(sp_data),
    .pid_start(pid_start), .pid_ch(pid_ch), .pid_setpoint(pid_setpoint), .pid_meas(pid_meas),
    .pid_done(pid_done), .pid_result(pid_result),
    .duty_0(duty_0), .duty_1(duty_1), .dir_0(dir_0), .dir_1(dir_1),
    .sample_tick(sample_tick), .update_done(update_done), .overrun(overrun),
    .timeout_flt(timeout_flt), .flt_clr(flt_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stub PID unit: latency 0 means it never answers.
  int                 lat_cfg [2];
  logic signed [15:0] res_cfg [2];
  bit                 start_seen = 0;
  logic               start_ch = 0;
  int                 pend = 0;
  logic signed [15:0] pres = 0;

  initial forever begin
    @(negedge clk);
    if (pid_start) begin
      start_seen = 1;
      start_ch   = pid_ch;
    end
  end

  initial begin
    pid_done   = 0;
    pid_result = 0;
    forever begin
      @(posedge clk);
      #1;
      pid_done = 0;
      if (CPU_RESET) begin
        pend       = 0;
        start_seen = 0;
      end else begin
        if (start_seen) begin
          pend       = lat_cfg[start_ch];
          pres       = res_cfg[start_ch];
          start_seen = 0;
        end
        if (pend != 0) begin
          if (pend == 1) begin
            pid_done   = 1;
            pid_result = pres;
          end
          pend--;
        end
      end
    end
  end

  // Reference model: tracks when each start/finish/apply event must occur.
  int                 cyc;
  bit                 busy, in_xact;
  int                 ch_m, latch_at, start_at, apply_at;
  logic signed [15:0] prev_m [2], meas_m [2], shadow_m [2], active_m [2], held_m [2];
  int                 duty_m [2];
  bit                 dir_m [2];
  bit                 ovr_m;
  bit [1:0]           to_m;
  logic signed [15:0] obs_meas [2], obs_sp [2];

  function automatic int m_duty(input logic signed [15:0] r);
    int m;
    m = (r < 0) ? -int'(r) : int'(r);
    return (m > 1000) ? 1000 : m;
  endfunction

  task automatic model_reset();
    cyc = 0; busy = 0; in_xact = 0; ch_m = 0;
    latch_at = -1; start_at = -1; apply_at = -1;
    ovr_m = 0; to_m = 0;
    for (int i = 0; i < 2; i++) begin
      prev_m[i] = 0; meas_m[i] = 0; shadow_m[i] = 0; active_m[i] = 0; held_m[i] = 0;
      duty_m[i] = 0; dir_m[i] = 0;
    end
  endtask

  initial begin
    bit       tk, set_o, fin;
    bit [1:0] set_t;
    model_reset();
    forever begin
      @(negedge clk);
      if (CPU_RESET) begin
        model_reset();
        continue;
      end
      tk = (cyc % DIV) == DIV - 1;
      chk("sample_tick", sample_tick, tk);
      chk("pid_start", pid_start, busy && enable && in_xact && cyc == start_at);
      chk("update_done", update_done, busy && cyc == apply_at);
      chk("duty_0", duty_0, duty_m[0]);
      chk("duty_1", duty_1, duty_m[1]);
      chk("dir", {dir_1, dir_0}, {dir_m[1], dir_m[0]});
      chk("overrun", overrun, ovr_m);
      chk("timeout_flt", timeout_flt, to_m);
      if (busy && enable && in_xact && cyc >= start_at) begin
        chk("pid_ch", pid_ch, ch_m[0]);
        chk("pid_setpoint", pid_setpoint, active_m[ch_m]);
        chk("pid_meas", pid_meas, meas_m[ch_m]);
      end
      if (pid_start) begin
        obs_meas[pid_ch] = pid_meas;
        obs_sp[pid_ch]   = pid_setpoint;
      end

      set_o = tk && busy;
      set_t = 2'b00;
      if (!enable) begin
        busy = 0; in_xact = 0;
        for (int i = 0; i < 2; i++) begin
          held_m[i] = 0; duty_m[i] = 0; dir_m[i] = 0;
        end
        if (tk) begin
          prev_m[0] = enc_count_0;
          prev_m[1] = enc_count_1;
        end
      end else if (busy) begin
        if (cyc == latch_at) begin
          meas_m[0] = enc_count_0 - prev_m[0];
          meas_m[1] = enc_count_1 - prev_m[1];
          prev_m[0] = enc_count_0;
          prev_m[1] = enc_count_1;
          active_m  = shadow_m;
        end else if (cyc == apply_at) begin
          for (int i = 0; i < 2; i++) begin
            duty_m[i] = m_duty(held_m[i]);
            dir_m[i]  = held_m[i] < 0;
          end
          busy = 0; in_xact = 0;
        end else if (in_xact && cyc > start_at) begin
          fin = 0;
          if (pid_done) begin
            held_m[ch_m] = pid_result;
            fin = 1;
          end else if (cyc == start_at + TO) begin
            set_t[ch_m] = 1'b1;
            fin = 1;
          end
          if (fin) begin
            if (ch_m == 0) begin
              ch_m = 1;
              start_at = cyc + 2;
            end else begin
              in_xact  = 0;
              apply_at = cyc + 2;
            end
          end
        end
      end else if (tk) begin
        busy = 1; in_xact = 1; ch_m = 0;
        latch_at = cyc + 1; start_at = cyc + 2; apply_at = -1;
      end
      if (sp_wr) shadow_m[sp_ch] = sp_data;
      ovr_m = (ovr_m && !flt_clr) || set_o;
      to_m  = (flt_clr ? 2'b00 : to_m) | set_t;
      cyc++;
    end
  end

  // Directed stimulus
  int last_lat;

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 40);
    if (!sample_tick) tmo("wait_tick");
  endtask

  task automatic run_sample(input logic signed [15:0] e0, input logic signed [15:0] e1,
                            input bit dsp, input logic spc, input logic signed [15:0] spv,
                            input int bound);
    time t0;
    int  n = 0;
    wait_tick();
    t0 = $time;
    @(posedge clk); #1;
    enc_count_0 = e0;
    enc_count_1 = e1;
    if (dsp) begin
      sp_wr = 1; sp_ch = spc; sp_data = spv;
    end
    @(posedge clk); #1;
    sp_wr = 0;
    while (!update_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!update_done) tmo("update_done");
    last_lat = int'(($time - t0) / 10);
    @(negedge clk);
  endtask

  task automatic write_sp(input logic ch, input logic signed [15:0] v);
    @(posedge clk); #1;
    sp_wr = 1; sp_ch = ch; sp_data = v;
    @(posedge clk); #1;
    sp_wr = 0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    flt_clr = 1;
    @(posedge clk); #1;
    flt_clr = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic signed [15:0] e0;
    CPU_RESET = 1; enable = 0; enc_count_0 = 0; enc_count_1 = 0;
    sp_wr = 0; sp_ch = 0; sp_data = 0; flt_clr = 0;
    lat_cfg[0] = 1; lat_cfg[1] = 1; res_cfg[0] = 0; res_cfg[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_duty", {duty_1, duty_0}, 0);
    chk("rst_pulses", {pid_start, sample_tick, update_done, dir_0, dir_1}, 0);
    chk("rst_faults", {overrun, timeout_flt}, 0);
    @(posedge clk); #1;
    CPU_RESET = 0;
    enable    = 1;

    run_sample(0, 0, 0, 0, 0, 50);
    chk("t1_latency", last_lat, 8);
    chk("t1_faults", {overrun, timeout_flt}, 0);

    write_sp(0, 50);
    res_cfg[0] = 1500; res_cfg[1] = -300;
    run_sample(20, 32760, 0, 0, 0, 50);
    chk("t2_meas0", obs_meas[0], 20);
    chk("t2_sp0", obs_sp[0], 50);
    chk("t2_duty0", duty_0, 1000);
    chk("t2_dir0", dir_0, 0);

    write_sp(1, 7);
    write_sp(1, 9);
    run_sample(40, -32766, 1, 0, 77, 50);
    chk("t3_meas1_wrap", obs_meas[1], 10);
    chk("t3_sp1_last_wins", obs_sp[1], 9);
    chk("t3_sp0_latch_write", obs_sp[0], 50);
    chk("t3_duty1", duty_1, 300);
    chk("t3_dir1", dir_1, 1);
    run_sample(60, -32766, 0, 0, 0, 50);
    chk("t3_sp0_next", obs_sp[0], 77);

    lat_cfg[0] = 0;
    run_sample(80, -32766, 0, 0, 0, 400);
    chk("t4_timeout", timeout_flt, 2'b01);
    chk("t4_duty0_kept", duty_0, 1000);
    chk("t4_duty1", duty_1, 300);
    chk("t4_overrun", overrun, 1);
    pulse_clr();
    chk("t4_clr", {overrun, timeout_flt}, 0);

    lat_cfg[0] = 20;
    flt_clr = 1;
    run_sample(100, -32766, 0, 0, 0, 80);
    @(posedge clk); #1;
    flt_clr = 0;
    run_sample(120, -32766, 0, 0, 0, 80);
    chk("t5_overrun", overrun, 1);
    pulse_clr();
    chk("t5_clr", overrun, 0);

    lat_cfg[0] = 4; lat_cfg[1] = 1; res_cfg[1] = -32768;
    wait_tick();
    @(posedge clk); #1;
    enc_count_0 = 140;
    n = 0;
    while (!pid_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!pid_start) tmo("t6_start");
    @(posedge clk); #1;
    enable = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_duty_off", {duty_1, duty_0}, 0);
    e0 = 140;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      @(posedge clk); #1;
      e0 = e0 + 500;
      enc_count_0 = e0;
    end
    wait_tick();
    @(posedge clk); #1;
    enable = 1;
    lat_cfg[0] = 1;
    run_sample(e0 + 16'sd20, -32766, 0, 0, 0, 50);
    chk("t6_no_spike", obs_meas[0], 20);
    chk("t6_sat_neg", duty_1, 1000);
    chk("t6_dir_neg", dir_1, 1);

    wait_tick();
    @(posedge clk); #1;
    @(posedge clk); #3;
    CPU_RESET = 1;
    #1;
    chk("t7_async_duty", {duty_1, duty_0}, 0);
    chk("t7_async_misc", {dir_1, dir_0, pid_start, pid_ch, overrun, timeout_flt}, 0);
    @(posedge clk); #1;
    CPU_RESET = 0;
    run_sample(e0 + 16'sd40, -32766, 0, 0, 0, 50);
    chk("t7_recover_duty0", duty_0, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_sample_scheduler.md
Name: pid_sample_scheduler

Overview:
- Sequences the closed-loop velocity update for the two motor channels from a shared, single-instance PID compute unit.
- Generates the control sample tick and latches encoder counts and host setpoints at each sample.
- Issues one start/done transaction per channel to the PID unit, then converts the results into duty and direction.
- Sits between the encoder counters, UART command decoder, PID unit and PWM generators.

Parameters:
- SAMPLE_DIV, 100000, clock cycles per control sample (1 kHz at 100 MHz); must be at least 16.
- PWM_W, 10, duty width in bits.
- DUTY_MAX, 1000, saturation limit for duty (must be at most 2^PWM_W-1).
- PID_TIMEOUT, 255, maximum cycles to wait for pid_done per channel.

Ports:
- CLK100MHZ  in  1  system clock
- CPU_RESET  in  1  asynchronous reset, active-high
- enable  in  1  loop enable
- enc_count_0  in  16  signed running encoder count, channel 0
- enc_count_1  in  16  signed running encoder count, channel 1
- sp_wr  in  1  setpoint write strobe
- sp_ch  in  1  setpoint channel select
- sp_data  in  16  signed setpoint (counts per sample)
- pid_start  out  1  one-cycle start pulse to the PID unit
- pid_ch  out  1  channel under computation
- pid_setpoint  out  16  signed setpoint for pid_ch
- pid_meas  out  16  signed measured velocity for pid_ch
- pid_done  in  1  result valid pulse
- pid_result  in  16  signed PID output
- duty_0, duty_1  out  PWM_W  unsigned duty
- dir_0, dir_1  out  1  direction (1 = result negative)
- sample_tick  out  1  one-cycle pulse per sample
- update_done  out  1  one-cycle pulse when duties are updated
- overrun  out  1  sticky: tick arrived while not IDLE
- timeout_flt  out  2  sticky per-channel PID timeout
- flt_clr  in  1  clears overrun and timeout_flt

Behaviour:
- Reset: all outputs 0; tick counter 0; FSM IDLE; prev counts, shadow/active setpoints, held results all 0.
- Tick counter: free-runs 0..SAMPLE_DIV-1; sample_tick high when count==SAMPLE_DIV-1, regardless of enable.
- FSM states: IDLE, LATCH, START, WAIT, STORE, APPLY; channel index ch.
  - IDLE: on sample_tick with enable=1, go to LATCH next cycle.
  - LATCH, one cycle:
    - meas_i = enc_count_i - prev_i, 16-bit modulo (wrap from 32767 to -32768 gives +1); prev_i <= enc_count_i.
    - active setpoints <= shadow setpoints; ch <= 0.
  - START: pid_start=1 for exactly one cycle; pid_ch, pid_setpoint and pid_meas are valid from START and held stable until pid_done.
  - WAIT: on pid_done, go to STORE. If pid_done has not arrived after PID_TIMEOUT cycles, set timeout_flt[ch], keep that channel's previous held result, and go to STORE without capture.
  - A pid_done arriving in the START cycle is ignored.
  - STORE: capture pid_result into held_result[ch] if done. If ch==0: ch <= 1, go to START. Else go to APPLY.
  - APPLY: for each channel, dir = sign of held result, duty = min(|result|, DUTY_MAX). |-32768| is 32768, so it saturates. Pulse update_done; go to IDLE.
  - Both duty/dir pairs change in the same APPLY cycle.
- Nominal latency, tick to update_done with 1-cycle PID: T+1 LATCH, T+2 START0, T+3 WAIT0/done, T+4 STORE0, T+5 START1, T+6 WAIT1, T+7 STORE1, T+8 APPLY.
- Overrun: sample_tick while FSM is not IDLE sets overrun; the tick is dropped and the current sequence continues.
- Setpoint writes:
  - sp_wr writes shadow[sp_ch] in any state.
  - A write in the LATCH cycle is not seen this sample; it is used next sample.
  - Two writes to the same channel before a LATCH: last one wins.
- enable low:
  - FSM aborts to IDLE next cycle; pid_start is never asserted while enable=0.
  - duty_0 and duty_1 are forced to 0 next cycle; held results are cleared.
  - A late pid_done after abort is ignored.
  - prev counts keep tracking enc_count every tick, so re-enable does not produce a velocity spike.
- flt_clr: clears overrun and timeout_flt. If clear and set occur in the same cycle, set wins.
- Asynchronous reset mid-sequence: everything returns to reset values immediately.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Channel count constant NUM_CH=2.
  - Function sat_abs(result, DUTY_MAX) returning duty and dir.
- One natural sub-module, sample_tick_gen: parameterised divider producing sample_tick.

Test Plan:
1. Reset and enable=1, counts static at 0, setpoints 0, stub PID returns 0 after 1 cycle -> update_done at T+8; duties 0, dirs 0, no faults.
2. sp_data=50 written to ch0, enc_count_0 steps +20 per sample, stub returns +1500 -> pid_meas=20, pid_setpoint=50; duty_0=1000 (saturated), dir_0=0.
3. Stub returns -300 for ch1; enc_count_1 wraps from 32760 to -32766 between samples -> pid_meas=+10 for ch1; duty_1=300, dir_1=1.
4. Stub never asserts pid_done for ch0 -> timeout_flt=01 after 255 cycles; ch1 still computed; duty_0 keeps its previous value.
5. Stub delays done beyond SAMPLE_DIV (SAMPLE_DIV=16 build) -> overrun=1; flt_clr clears it; only one update_done per completed sequence.
6. Deassert enable during WAIT0, then stub asserts done -> duties 0 next cycle, no capture, no further pid_start.
